// File: rtl/uart_arb.sv
// Round-robin arbiter sharing one uart_tx among NREQ character sources.
// A grant spans a whole message; a stalled owner is released after TIMEOUT idle cycles.
module uart_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1_000_000,
    parameter int TW      = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [8*NREQ-1:0] i_req_char,
    input  logic [NREQ-1:0]   i_req_last,
    output logic [NREQ-1:0]   o_req_ready,
    output logic [NREQ-1:0]   o_grant,
    output logic [7:0]        o_char,
    output logic              o_write,
    input  logic              i_busy
);
    localparam int            IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_RST   = IW'(NREQ - 1);
    localparam logic [TW-1:0] TIMEOUT_M1 = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SEND,
        S_GUARD,
        S_WAIT
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   last_owner_q;
    logic            last_flag_q;
    logic [TW-1:0]   tcnt_q;
    logic [NREQ-1:0] grant_q;
    logic [7:0]      char_q;
    logic            write_q;

    logic            owner_valid;
    logic            owner_last;
    logic [7:0]      owner_char;
    logic            xfer;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;

    assign owner_valid = i_req_valid[owner_q];
    assign owner_last  = i_req_last[owner_q];
    assign owner_char  = i_req_char[{owner_q, 3'b000} +: 8];
    assign xfer        = (state_q == S_ISSUE) && owner_valid && !i_busy;

    assign o_req_ready = ((state_q == S_ISSUE) && !i_busy) ? grant_q : '0;
    assign o_grant     = grant_q;
    assign o_char      = char_q;
    assign o_write     = write_q;

    // Walk offsets from farthest to nearest so the first valid index after last_owner wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_owner_q) + k) % NREQ;
            if (i_req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(idx);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_RST;
            last_flag_q  <= 1'b0;
            tcnt_q       <= '0;
            grant_q      <= '0;
            char_q       <= 8'h00;
            write_q      <= 1'b0;
        end else begin
            write_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tcnt_q <= '0;
                    if (pick_found) begin
                        owner_q <= pick_idx;
                        grant_q <= NREQ'(1) << pick_idx;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (xfer) begin
                        char_q      <= owner_char;
                        last_flag_q <= owner_last;
                        write_q     <= 1'b1;
                        tcnt_q      <= '0;
                        state_q     <= S_SEND;
                    end else if (!owner_valid && (TIMEOUT != 0)) begin
                        // Owner went quiet mid-message: drop it without sending anything.
                        if (tcnt_q == TIMEOUT_M1) begin
                            last_owner_q <= owner_q;
                            grant_q      <= '0;
                            tcnt_q       <= '0;
                            state_q      <= S_IDLE;
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                end
                S_SEND: begin
                    state_q <= S_GUARD;
                end
                S_GUARD: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (!i_busy) begin
                        if (last_flag_q) begin
                            last_owner_q <= owner_q;
                            grant_q      <= '0;
                            state_q      <= S_IDLE;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_arb.sv
// Self-checking bench for uart_arb: a cycle table for a single message, then
// queue-driven requesters and a uart_tx busy model for the multi-cycle scenarios.
module tb_uart_arb;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 50;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [NREQ-1:0]   i_req_valid = '0;
    logic [8*NREQ-1:0] i_req_char = '0;
    logic [NREQ-1:0]   i_req_last = '0;
    logic [NREQ-1:0]   o_req_ready;
    logic [NREQ-1:0]   o_grant;
    logic [7:0]        o_char;
    logic              o_write;
    logic              i_busy = 1'b0;

    uart_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(20)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req_valid(i_req_valid),
        .i_req_char (i_req_char),
        .i_req_last (i_req_last),
        .o_req_ready(o_req_ready),
        .o_grant    (o_grant),
        .o_char     (o_char),
        .o_write    (o_write),
        .i_busy     (i_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          cycles;
        logic [3:0]  valid;
        logic [31:0] chars;
        logic [3:0]  last;
        logic [3:0]  expGrant;
        logic [3:0]  expReady;
        logic        expWrite;
        logic [7:0]  expChar;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         busyLen = 0;
    int         busyCnt = 0;
    logic       busyHold = 1'b0;
    logic       prevWrite = 1'b0;
    logic       useQueues = 1'b0;
    int         foreignReady = 0;
    logic [8:0] reqQ [NREQ][$];
    logic [11:0] wlog[$];
    vec_t       vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        i_req_valid = v.valid;
        i_req_char  = v.chars;
        i_req_last  = v.last;
    endtask

    task automatic driveReqs();
        for (int n = 0; n < NREQ; n++) begin
            if (reqQ[n].size() != 0) begin
                i_req_valid[n]        = 1'b1;
                i_req_last[n]         = reqQ[n][0][8];
                i_req_char[8*n +: 8]  = reqQ[n][0][7:0];
            end else begin
                i_req_valid[n]        = 1'b0;
                i_req_last[n]         = 1'b0;
                i_req_char[8*n +: 8]  = 8'h00;
            end
        end
    endtask

    // One clock: update the uart_tx busy model, log writes, advance requester queues.
    task automatic step();
        logic [NREQ-1:0] xfer;
        xfer = i_req_valid & o_req_ready;
        @(posedge i_clk);
        #1;
        cycle++;
        if (o_write) begin
            busyCnt = busyLen;
            wlog.push_back({o_grant, o_char});
            checkOutput("write pulse width", {31'd0, prevWrite}, 32'd0);
        end else if (busyCnt > 0) begin
            busyCnt--;
        end
        prevWrite = o_write;
        i_busy = busyHold || (busyCnt != 0);
        if (useQueues) begin
            for (int n = 0; n < NREQ; n++) begin
                if (xfer[n] && reqQ[n].size() != 0) void'(reqQ[n].pop_front());
            end
            driveReqs();
        end
        #1;
        if ((o_req_ready & ~o_grant) != '0) foreignReady++;
    endtask

    task automatic clearBench();
        for (int n = 0; n < NREQ; n++) reqQ[n].delete();
        busyCnt  = 0;
        busyHold = 1'b0;
        i_busy   = 1'b0;
        i_req_valid = '0;
        i_req_char  = '0;
        i_req_last  = '0;
    endtask

    task automatic doReset();
        i_rst_n = 1'b0;
        clearBench();
        step();
        step();
        i_rst_n = 1'b1;
        prevWrite = 1'b0;
        wlog.delete();
    endtask

    task automatic waitWrites(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (wlog.size() < n && k < budget) begin
            step();
            k++;
        end
        checkOutput(name, wlog.size(), n);
    endtask

    function automatic logic [11:0] logEntry(input int i);
        if (i < wlog.size()) return wlog[i];
        return 12'hFFF;
    endfunction

    initial begin
        int t0;
        int t1;
        int k;
        int viol;

        // Requester 1 sends "AB"; uart_tx stays busy 10 cycles per character.
        vecs.push_back('{1,  4'b0010, 32'h0000_4100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00});
        vecs.push_back('{1,  4'b0010, 32'h0000_4100, 4'b0000, 4'b0010, 4'b0010, 1'b0, 8'h00});
        vecs.push_back('{1,  4'b0010, 32'h0000_4200, 4'b0010, 4'b0010, 4'b0000, 1'b1, 8'h41});
        vecs.push_back('{10, 4'b0010, 32'h0000_4200, 4'b0010, 4'b0010, 4'b0000, 1'b0, 8'h41});
        vecs.push_back('{1,  4'b0010, 32'h0000_4200, 4'b0010, 4'b0010, 4'b0010, 1'b0, 8'h41});
        vecs.push_back('{1,  4'b0000, 32'h0000_0000, 4'b0000, 4'b0010, 4'b0000, 1'b1, 8'h42});
        vecs.push_back('{10, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 8'h42});
        vecs.push_back('{2,  4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h42});

        doReset();
        checkOutput("reset grant", o_grant, 0);
        checkOutput("reset ready", o_req_ready, 0);
        checkOutput("reset write", o_write, 0);
        checkOutput("reset char", o_char, 0);

        busyLen = 10;
        useQueues = 1'b0;
        for (int r = 0; r < vecs.size(); r++) begin
            for (int c = 0; c < vecs[r].cycles; c++) begin
                applyStimulus(vecs[r]);
                #1;
                checkOutput($sformatf("AB row%0d grant", r), o_grant, vecs[r].expGrant);
                checkOutput($sformatf("AB row%0d ready", r), o_req_ready, vecs[r].expReady);
                checkOutput($sformatf("AB row%0d write", r), o_write, vecs[r].expWrite);
                checkOutput($sformatf("AB row%0d char", r), o_char, vecs[r].expChar);
                step();
            end
        end

        // Requesters 0 and 2 with 3-character messages must not interleave.
        doReset();
        useQueues = 1'b1;
        busyLen = 3;
        reqQ[0] = '{9'h010, 9'h011, 9'h112};
        reqQ[2] = '{9'h020, 9'h021, 9'h122};
        driveReqs();
        waitWrites(6, 200, "two-req write count");
        checkOutput("two-req log0", logEntry(0), 12'h1_10);
        checkOutput("two-req log1", logEntry(1), 12'h1_11);
        checkOutput("two-req log2", logEntry(2), 12'h1_12);
        checkOutput("two-req log3", logEntry(3), 12'h4_20);
        checkOutput("two-req log4", logEntry(4), 12'h4_21);
        checkOutput("two-req log5", logEntry(5), 12'h4_22);
        reqQ[0] = '{9'h115};
        reqQ[3] = '{9'h135};
        driveReqs();
        waitWrites(8, 100, "after-2 write count");
        checkOutput("search from 3 log6", logEntry(6), 12'h8_35);
        checkOutput("search from 3 log7", logEntry(7), 12'h1_15);

        // All four requesters streaming single-character messages.
        doReset();
        busyLen = 2;
        for (int n = 0; n < NREQ; n++) begin
            for (int m = 0; m < 3; m++) reqQ[n].push_back(9'h130 + 9'(n));
        end
        driveReqs();
        waitWrites(12, 500, "fairness write count");
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("fairness log%0d", i), logEntry(i),
                        {4'(1 << (i % 4)), 8'h30 + 8'(i % 4)});
        end

        // Requester 1 stalls mid-message; requester 3 waits behind it.
        doReset();
        busyLen = 3;
        reqQ[1] = '{9'h051};
        driveReqs();
        waitWrites(1, 20, "timeout first write");
        reqQ[3] = '{9'h173};
        driveReqs();
        k = 0;
        while (o_req_ready != 4'b0010 && k < 50) begin
            step();
            k++;
        end
        checkOutput("timeout reissue ready", o_req_ready, 4'b0010);
        t0 = cycle;
        k = 0;
        while (o_grant != 4'b0000 && k < 100) begin
            step();
            k++;
        end
        t1 = cycle;
        checkOutput("timeout release cycles", t1 - t0, TIMEOUT);
        waitWrites(2, 50, "timeout second write");
        checkOutput("timeout log0", logEntry(0), 12'h2_51);
        checkOutput("timeout log1", logEntry(1), 12'h8_73);

        // uart_tx busy held for 200 cycles after the first character.
        doReset();
        busyLen = 0;
        reqQ[0] = '{9'h061, 9'h162};
        driveReqs();
        waitWrites(1, 20, "hold first write");
        busyHold = 1'b1;
        viol = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (o_req_ready != '0 || o_write) viol++;
        end
        checkOutput("hold no ready/write", viol, 0);
        busyHold = 1'b0;
        step();
        checkOutput("hold busy-fall cycle ready", o_req_ready, 4'b0000);
        step();
        checkOutput("hold ready after fall", o_req_ready, 4'b0001);
        waitWrites(2, 20, "hold second write");
        checkOutput("hold log1", logEntry(1), 12'h1_62);

        // Reset while o_write is high, then reset during WAIT.
        doReset();
        busyLen = 10;
        reqQ[1] = '{9'h081, 9'h182};
        driveReqs();
        waitWrites(1, 20, "rst-send write");
        checkOutput("rst-send write before", o_write, 1);
        i_rst_n = 1'b0;
        #1;
        checkOutput("rst-send write async", o_write, 0);
        checkOutput("rst-send grant async", o_grant, 0);
        doReset();
        reqQ[1] = '{9'h081, 9'h182};
        driveReqs();
        waitWrites(1, 20, "rst-wait write");
        step();
        step();
        step();
        checkOutput("rst-wait grant before", o_grant, 4'b0010);
        i_rst_n = 1'b0;
        #1;
        checkOutput("rst-wait grant", o_grant, 0);
        checkOutput("rst-wait ready", o_req_ready, 0);
        checkOutput("rst-wait write", o_write, 0);
        checkOutput("rst-wait char", o_char, 0);
        doReset();
        reqQ[0] = '{9'h190};
        reqQ[2] = '{9'h192};
        driveReqs();
        waitWrites(2, 50, "post-reset writes");
        checkOutput("post-reset log0", logEntry(0), 12'h1_90);
        checkOutput("post-reset log1", logEntry(1), 12'h4_92);

        checkOutput("no ready to non-owner", foreignReady, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_arb.md
# uart_arb

Round-robin arbiter sharing a single `uart_tx` among `NREQ` character sources, such as `uart_buf` instances or debug/status emitters. Sits between the requesters and `uart_tx`, driving that block's `i_char`/`i_write` and observing its `o_busy`. A grant is held for a whole message, from first character to the character flagged `last`, so messages never interleave on the line. An idle-timeout releases a requester that stalls mid-message.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 1_000_000: cycles a granted requester may hold `valid` low mid-message before the grant is revoked; 0 disables the timeout.
- `TW`, default 20: width of the timeout counter; must hold `TIMEOUT`.

Ports:
- `i_clk`  in  1  single clock, the oscillator clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  NREQ  per-requester character valid.
- `i_req_char`  in  8*NREQ  character of requester n at bits [8n+7:8n].
- `i_req_last`  in  NREQ  marks the current character as end of message.
- `o_req_ready`  out  NREQ  per-requester accept; a transfer occurs when valid & ready.
- `o_grant`  out  NREQ  one-hot current owner; 0 when no owner.
- `o_char`  out  8  to `uart_tx` `i_char`.
- `o_write`  out  1  to `uart_tx` `i_write`; one-cycle pulse.
- `i_busy`  in  1  from `uart_tx` `o_busy`.

## Operation
- States: IDLE, ISSUE, SEND, GUARD, WAIT.
- IDLE:
  - If any `i_req_valid` is high, choose the first valid index searching from `(last_owner+1) mod NREQ` upward with wrap.
  - Register the choice as owner, set `o_grant`, go to ISSUE.
  - With no valid requester, stay in IDLE.
- ISSUE:
  - `o_req_ready[owner] = !i_busy` (combinational); all other ready bits are 0.
  - On transfer, register `o_char` and `last_flag`, set `o_write` for the next cycle, clear the timeout counter, go to SEND.
  - When `i_req_valid[owner]` is low, the timeout counter increments.
  - If `TIMEOUT != 0` and the counter reaches `TIMEOUT`, release the grant (`last_owner = owner`, `o_grant = 0`) and go to IDLE. No partial character is sent.
- SEND: `o_write` is high for exactly this cycle. Go to GUARD.
- GUARD: one cycle, `i_busy` ignored, covering `uart_tx` raising busy the cycle after the write. Go to WAIT.
- WAIT:
  - Hold while `i_busy` is high.
  - When `i_busy` is low and `last_flag` is set: release the grant (`last_owner = owner`, `o_grant = 0`) and go to IDLE.
  - When `i_busy` is low and `last_flag` is clear: go to ISSUE.
- Requesters other than the owner are never readied, whatever their `valid`.
- `i_req_char` and `i_req_last` are sampled only on the transfer cycle. Requesters hold them stable while valid is high and not readied.

## Timing
- Reset (async assert, sync deassert by the surrounding logic):
  - State IDLE.
  - `o_write=0`, `o_char=8'h00`, `o_grant=0`, `o_req_ready=0`.
  - `last_owner=NREQ-1`, so requester 0 wins the first arbitration.
  - Timeout counter 0.
- Reset asserted mid-message drops the message immediately. `o_write` falls asynchronously, and no further `o_write` occurs until a new arbitration.
- Latency with `i_busy` low:
  - Valid seen in IDLE at cycle 0.
  - Grant and ready at cycle 1.
  - `o_write` at cycle 2.
- Back-to-back characters within a message: next ready no earlier than 3 cycles after the previous transfer (SEND, GUARD, WAIT).
- Between messages: the release cycle is followed by one IDLE arbitration cycle, so another requester's first `o_write` comes no earlier than 3 cycles after the release.
- Simultaneous valid in IDLE: round-robin order only; no fixed priority.
- Requester raising valid while another owns the grant waits until release; no starvation beyond `NREQ-1` messages.
- `o_write` is never asserted while the previous character's WAIT has not seen `i_busy` low.

## Test plan
- Single requester 1 sends "AB" (`last` on 'B'), `uart_tx` model busy for 10 cycles per char: `o_write` pulses carry 0x41 then 0x42, each 1 cycle wide. `o_grant` is 4'b0010 from cycle 1 through the 'B' WAIT, then 0.
- Requesters 0 and 2 both valid from reset, each with a 3-char message: all 3 chars of requester 0 go out, then all 3 of requester 2, with no interleaving. Next arbitration starts searching at index 3.
- Round-robin fairness: all 4 requesters continuously send 1-char messages: grant sequence is 0,1,2,3,0,1,… over 12 messages.
- Timeout with `TIMEOUT=50`: requester 1 sends one non-last char, then drops valid. Grant releases exactly 50 cycles after the counter starts. Requester 3, valid meanwhile, sends next.
- Busy hold: `i_busy` held high for 200 cycles after a write: no `o_req_ready`, no `o_write` during the hold. Next ready comes the cycle after `i_busy` falls.
- Reset mid-message: `i_rst_n` pulled low during WAIT: all outputs go to their reset values immediately. After release, requester 0 wins.
